// File: rtl/paddle_ctrl.sv
// paddle_ctrl: Pong paddle position controller.
// Turns two raw active-low buttons, or an auto-track target, into a registered
// paddle top-edge coordinate. Movement happens once per prescaler tick and
// accelerates when a direction is held. The result is clamped to the playfield.
module paddle_ctrl #(
  parameter int WIDTH       = 10,
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 100,
  parameter int Y_RESET     = 100,
  parameter int TICK_DIV    = 262144,
  parameter int ACCEL_TICKS = 8,
  parameter int SLOW_STEP   = 1,
  parameter int FAST_STEP   = 4,
  parameter int AI_STEP     = 2,
  parameter int DEADBAND    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_up_n,
  input  logic             btn_down_n,
  input  logic             ai_en,
  input  logic [WIDTH-1:0] target_y,
  output logic [WIDTH-1:0] y_pos,
  output logic             at_top,
  output logic             at_bottom,
  output logic             upd
);

  localparam int Y_LIMIT = SCREEN_H - PADDLE_H;
  localparam int CNT_W   = $clog2(TICK_DIV);
  localparam int HOLD_W  = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS + 1) : 1;
  localparam int CW      = WIDTH + 1;  // width of the paddle-centre sum
  localparam int AW      = WIDTH + 2;  // signed working width of position arithmetic

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLOW = 2'd1,
    S_FAST = 2'd2
  } speed_t;

  // Button synchronisers (idle level is 1 = released)
  logic r_up_meta;
  logic r_up_sync;
  logic r_dn_meta;
  logic r_dn_sync;

  // Movement prescaler
  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  // Speed FSM state
  speed_t            r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_last_dn;   // direction of the current run: 1 = down

  // Registered outputs
  logic [WIDTH-1:0] r_y_pos;
  logic             r_at_top;
  logic             r_at_bottom;
  logic             r_upd;

  // Decoded manual direction
  logic w_press_up;
  logic w_press_dn;
  logic w_dir_up;
  logic w_dir_dn;
  logic w_dir_any;
  logic w_restart;
  logic [HOLD_W-1:0] w_hold_inc;

  // Auto-track comparison
  logic [CW-1:0] w_centre;
  logic [AW-1:0] w_centre_ext;
  logic [AW-1:0] w_target_ext;
  logic          w_ai_up;
  logic          w_ai_dn;

  // Position arithmetic
  logic [AW-1:0]    w_step;
  logic             w_move_dn;
  logic [AW-1:0]    w_y_ext;
  logic [AW-1:0]    w_sum;
  logic [WIDTH-1:0] w_y_next;

  // Bring both raw buttons into the clk domain through two flops each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_meta <= 1'b1;
      r_up_sync <= 1'b1;
      r_dn_meta <= 1'b1;
      r_dn_sync <= 1'b1;
    end else begin
      r_up_meta <= btn_up_n;
      r_up_sync <= r_up_meta;
      r_dn_meta <= btn_down_n;
      r_dn_sync <= r_dn_meta;
    end
  end

  // The tick is the last count of each prescaler period
  assign w_tick = (r_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running prescaler, restarts from zero after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Both buttons pressed cancel each other out
  assign w_press_up = ~r_up_sync;
  assign w_press_dn = ~r_dn_sync;
  assign w_dir_up   = w_press_up & ~w_press_dn;
  assign w_dir_dn   = w_press_dn & ~w_press_up;
  assign w_dir_any  = w_dir_up | w_dir_dn;

  // A run restarts from SLOW when starting from rest or on a reversal
  assign w_restart  = w_dir_any & ((r_state == S_IDLE) | (w_dir_dn != r_last_dn));
  assign w_hold_inc = (r_hold >= HOLD_W'(ACCEL_TICKS)) ? r_hold : (r_hold + HOLD_W'(1));

  // Paddle centre and hysteresis window, all compared unsigned in AW bits
  assign w_centre     = {1'b0, r_y_pos} + CW'(PADDLE_H / 2);
  assign w_centre_ext = AW'(w_centre);
  assign w_target_ext = AW'(target_y);
  assign w_ai_up      = (w_target_ext + AW'(DEADBAND)) < w_centre_ext;
  assign w_ai_dn      = w_target_ext > (w_centre_ext + AW'(DEADBAND));

  // Choose step magnitude and direction for this tick
  always_comb begin
    w_step    = '0;
    w_move_dn = 1'b0;
    if (ai_en) begin
      if (w_ai_up) begin
        w_step    = AW'(AI_STEP);
        w_move_dn = 1'b0;
      end else if (w_ai_dn) begin
        w_step    = AW'(AI_STEP);
        w_move_dn = 1'b1;
      end
    end else if (w_dir_any) begin
      w_move_dn = w_dir_dn;
      // The tick that promotes SLOW to FAST still moves at the slow rate
      if (!w_restart && (r_state == S_FAST)) begin
        w_step = AW'(FAST_STEP);
      end else begin
        w_step = AW'(SLOW_STEP);
      end
    end
  end

  // An up-move past zero wraps negative in AW bits, which sets the top bit
  assign w_y_ext = AW'(r_y_pos);
  assign w_sum   = w_move_dn ? (w_y_ext + w_step) : (w_y_ext - w_step);

  // Clamp the candidate position to [0, Y_LIMIT]
  always_comb begin
    w_y_next = w_sum[WIDTH-1:0];
    if (w_sum[AW-1]) begin
      w_y_next = '0;
    end else if (w_sum > AW'(Y_LIMIT)) begin
      w_y_next = WIDTH'(Y_LIMIT);
    end
  end

  // Speed FSM: tracks how long one manual direction has been held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_last_dn <= 1'b0;
    end else if (w_tick) begin
      if (ai_en || !w_dir_any) begin
        r_state <= S_IDLE;
        r_hold  <= '0;
      end else begin
        r_last_dn <= w_dir_dn;
        if (w_restart) begin
          r_state <= S_SLOW;
          r_hold  <= HOLD_W'(1);
        end else begin
          // Wall contact does not interrupt the run; only dir changes do
          r_hold <= w_hold_inc;
          if (w_hold_inc >= HOLD_W'(ACCEL_TICKS)) begin
            r_state <= S_FAST;
          end
        end
      end
    end
  end

  // Register position, wall flags and the update pulse together on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_pos     <= WIDTH'(Y_RESET);
      r_at_top    <= (Y_RESET == 0);
      r_at_bottom <= (Y_RESET == Y_LIMIT);
      r_upd       <= 1'b0;
    end else if (w_tick) begin
      r_y_pos     <= w_y_next;
      r_at_top    <= (w_y_next == '0);
      r_at_bottom <= (w_y_next == WIDTH'(Y_LIMIT));
      r_upd       <= (w_y_next != r_y_pos);
    end else begin
      r_upd <= 1'b0;
    end
  end

  assign y_pos     = r_y_pos;
  assign at_top    = r_at_top;
  assign at_bottom = r_at_bottom;
  assign upd       = r_upd;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Testbench for paddle_ctrl: drives buttons/auto-track per tick and compares
// against a run-length based reference model of the paddle behaviour.
module tb_paddle_ctrl;

  localparam int W  = 10;
  localparam int SH = 480;
  localparam int PH = 100;
  localparam int YR = 100;
  localparam int TD = 4;
  localparam int AT = 3;
  localparam int SS = 1;
  localparam int FS = 4;
  localparam int AI = 2;
  localparam int DB = 4;
  localparam int YL = SH - PH;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b1;
  logic         btn_up_n   = 1'b1;
  logic         btn_down_n = 1'b1;
  logic         ai_en      = 1'b0;
  logic [W-1:0] target_y   = '0;
  logic [W-1:0] y_pos;
  logic         at_top;
  logic         at_bottom;
  logic         upd;

  int errors = 0;
  int checks = 0;

  // Reference model state: position, length of current same-direction run
  int m_y   = YR;
  int m_run = 0;
  int m_dir = 0;
  bit m_upd = 1'b0;

  paddle_ctrl #(
    .WIDTH(W), .SCREEN_H(SH), .PADDLE_H(PH), .Y_RESET(YR), .TICK_DIV(TD),
    .ACCEL_TICKS(AT), .SLOW_STEP(SS), .FAST_STEP(FS), .AI_STEP(AI), .DEADBAND(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
    .ai_en(ai_en), .target_y(target_y), .y_pos(y_pos), .at_top(at_top),
    .at_bottom(at_bottom), .upd(upd)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_y   = YR;
    m_run = 0;
    m_dir = 0;
    m_upd = 1'b0;
  endfunction

  // One movement tick: manual step grows to FAST once a run exceeds AT ticks
  function automatic void model_tick(input bit up, input bit dn, input bit ai, input int tgt);
    int dir;
    int step;
    int nxt;
    int c;
    nxt = m_y;
    if (ai) begin
      m_run = 0;
      m_dir = 0;
      c = m_y + PH / 2;
      if (tgt + DB < c) nxt = m_y - AI;
      else if (tgt > c + DB) nxt = m_y + AI;
    end else begin
      dir = 0;
      if (up && !dn) dir = -1;
      else if (dn && !up) dir = 1;
      if (dir == 0) m_run = 0;
      else if (dir == m_dir) m_run = m_run + 1;
      else m_run = 1;
      m_dir = dir;
      step = (m_run > AT) ? FS : SS;
      nxt = m_y + dir * step;
    end
    if (nxt < 0) nxt = 0;
    if (nxt > YL) nxt = YL;
    m_upd = (nxt != m_y);
    m_y = nxt;
  endfunction

  function automatic logic [W+3:0] expected();
    return {W'(m_y), m_upd, (m_y == 0), (m_y == YL), 1'b0};
  endfunction

  task automatic drive(input bit up, input bit dn, input bit ai, input int tgt);
    btn_up_n   = ~up;
    btn_down_n = ~dn;
    ai_en      = ai;
    target_y   = W'(tgt);
  endtask

  // Advance one full tick period from a post-tick negedge; early=1 if any
  // output moved or upd pulsed before the tick edge
  task automatic advance_tick(output bit early);
    logic [W-1:0] y0;
    y0 = y_pos;
    early = 1'b0;
    for (int i = 0; i < TD; i++) begin
      @(negedge clk);
      if (i < TD - 1 && (upd !== 1'b0 || y_pos !== y0)) early = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bit early;
    logic [W+3:0] obs;
    bit seen_upd;
    drive(0, 0, 0, 0);
    do_reset(3);
    checks++;
    if (y_pos !== W'(YR) || at_top !== 1'b0 || at_bottom !== 1'b0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got y=%0d top=%b bot=%b upd=%b, expected y=%0d top=0 bot=0 upd=0",
               y_pos, at_top, at_bottom, upd, YR);
    end
    seen_upd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      advance_tick(early);
      model_tick(0, 0, 0, 0);
      if (upd === 1'b1 || early) seen_upd = 1'b1;
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL idle[%0d]: got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
    checks++;
    if (seen_upd) begin
      errors++;
      $display("FAIL idle_no_upd: got upd activity=1, expected 0");
    end
  endtask

  task automatic test_accel();
    bit early;
    logic [W+3:0] obs;
    for (int k = 0; k < 8; k++) begin
      bit dn;
      dn = (k < 6);
      drive(0, dn, 0, 0);
      advance_tick(early);
      model_tick(0, dn, 0, 0);
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL accel[%0d]: got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
    checks++;
    if (y_pos !== 10'd115) begin
      errors++;
      $display("FAIL accel_final: got y=%0d, expected 115", y_pos);
    end
  endtask

  task automatic test_walls();
    bit early;
    logic [W+3:0] obs;
    int extra;
    extra = 0;
    for (int k = 0; k < 150 && extra < 3; k++) begin
      drive(0, 1, 0, 0);
      advance_tick(early);
      model_tick(0, 1, 0, 0);
      if (m_y == YL) extra++;
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL wall_down[%0d]: got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
    checks++;
    if (at_bottom !== 1'b1 || y_pos !== W'(YL) || upd !== 1'b0) begin
      errors++;
      $display("FAIL wall_bottom: got y=%0d bot=%b upd=%b, expected y=%0d bot=1 upd=0",
               y_pos, at_bottom, upd, YL);
    end
    extra = 0;
    for (int k = 0; k < 150 && extra < 3; k++) begin
      drive(1, 0, 0, 0);
      advance_tick(early);
      model_tick(1, 0, 0, 0);
      if (m_y == 0) extra++;
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL wall_up[%0d]: got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
    checks++;
    if (at_top !== 1'b1 || y_pos !== '0 || upd !== 1'b0) begin
      errors++;
      $display("FAIL wall_top: got y=%0d top=%b upd=%b, expected y=0 top=1 upd=0",
               y_pos, at_top, upd);
    end
  endtask

  task automatic test_both();
    bit early;
    logic [W+3:0] obs;
    for (int k = 0; k < 3; k++) begin
      bit up;
      up = (k < 2);
      drive(up, 1, 0, 0);
      advance_tick(early);
      model_tick(up, 1, 0, 0);
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL both[%0d]: got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
    checks++;
    if (y_pos !== 10'd1 || upd !== 1'b1) begin
      errors++;
      $display("FAIL both_release: got y=%0d upd=%b, expected y=1 upd=1", y_pos, upd);
    end
  endtask

  task automatic test_auto();
    bit early;
    logic [W+3:0] obs;
    do_reset(2);
    for (int k = 0; k < 130; k++) begin
      bit up;
      bit dn;
      up = bit'($urandom % 2);
      dn = bit'($urandom % 2);
      drive(up, dn, 1, 400);
      advance_tick(early);
      model_tick(up, dn, 1, 400);
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL auto_track[%0d]: got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
    checks++;
    if (y_pos !== 10'd346 || upd !== 1'b0) begin
      errors++;
      $display("FAIL auto_settle: got y=%0d upd=%b, expected y=346 upd=0", y_pos, upd);
    end
    for (int k = 0; k < 30; k++) begin
      int tgt;
      tgt = int'($urandom_range(1023, 0));
      drive(bit'($urandom % 2), bit'($urandom % 2), 1, tgt);
      advance_tick(early);
      model_tick(0, 0, 1, tgt);
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL auto_rand[%0d]: tgt=%0d got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, tgt, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit early;
    logic [W+3:0] obs;
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 0);
      advance_tick(early);
      model_tick(0, 1, 0, 0);
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL pre_reset[%0d]: got y=%0d upd=%b early=%b, expected y=%0d upd=%b",
                 k, y_pos, upd, early, m_y, m_upd);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (y_pos !== W'(YR) || upd !== 1'b0 || at_top !== 1'b0 || at_bottom !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got y=%0d upd=%b top=%b bot=%b, expected y=%0d upd=0 top=0 bot=0",
               y_pos, upd, at_top, at_bottom, YR);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    advance_tick(early);
    model_tick(0, 1, 0, 0);
    obs = {y_pos, upd, at_top, at_bottom, early};
    checks++;
    if (obs !== expected()) begin
      errors++;
      $display("FAIL post_reset_tick: got y=%0d upd=%b early=%b, expected y=%0d upd=%b early=0",
               y_pos, upd, early, m_y, m_upd);
    end
    checks++;
    if (y_pos !== 10'd101 || upd !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_slow: got y=%0d upd=%b, expected y=101 upd=1", y_pos, upd);
    end
  endtask

  task automatic test_random();
    bit early;
    logic [W+3:0] obs;
    for (int k = 0; k < 80; k++) begin
      bit up;
      bit dn;
      bit ai;
      int tgt;
      up  = ($urandom % 4) != 0;
      dn  = ($urandom % 3) == 0;
      ai  = ($urandom % 4) == 0;
      tgt = int'($urandom_range(1023, 0));
      if (k >= 40) begin
        up = ~up;
        dn = ~dn;
      end
      drive(up, dn, ai, tgt);
      advance_tick(early);
      model_tick(up, dn, ai, tgt);
      obs = {y_pos, upd, at_top, at_bottom, early};
      checks++;
      if (obs !== expected()) begin
        errors++;
        $display("FAIL random[%0d]: up=%b dn=%b ai=%b tgt=%0d got y=%0d upd=%b top=%b bot=%b early=%b, expected y=%0d upd=%b",
                 k, up, dn, ai, tgt, y_pos, upd, at_top, at_bottom, early, m_y, m_upd);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_accel();
    test_walls();
    test_both();
    test_auto();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
